frame_tx_packer: RTL

Upstream frame source for the channel-demux receive path. It accepts a transmit command (target channel, payload length) and 1–8 payload words over valid/ready handshakes, and buffers the whole payload while computing CRC-16. It then emits one contiguous, gap-free frame on a 16-bit bus at one word per clock. Its `data_out` connects directly to the `data_in` of the frame-detect/FIFO/serialiser top, in the same `clk_in` domain.

---
 rtl/frame_tx_packer_if.sv | 40 ++++
 rtl/frame_tx_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_packer_if.sv
// -----------------------------------------------------------------------------
// frame_tx_packer_if
// Bundles the command, payload and frame-output signals of frame_tx_packer.
//   cmd_valid / cmd_ready     : command handshake
//   cmd_channel[7:0]          : one-hot target channel
//   cmd_len[3:0]              : payload length in 16-bit words (1..MAX_WORDS)
//   cmd_bad_crc               : send the inverted CRC (error injection)
//   pld_valid / pld_ready     : payload word handshake
//   pld_data[15:0]            : payload word, first word most significant
//   data_out[15:0]            : registered frame word stream, 0 when idle
//   busy                      : a frame is being loaded or emitted
//   frame_done                : pulse with the last trailer word
//   cmd_err                   : pulse after a rejected command
// master = frame producer side (drives commands/payload),
// slave  = the packer itself.
// -----------------------------------------------------------------------------
interface frame_tx_packer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_channel;
    logic [3:0]  cmd_len;
    logic        cmd_bad_crc;
    logic        pld_valid;
    logic        pld_ready;
    logic [15:0] pld_data;
    logic [15:0] data_out;
    logic        busy;
    logic        frame_done;
    logic        cmd_err;

    modport master (
        output cmd_valid, cmd_channel, cmd_len, cmd_bad_crc, pld_valid, pld_data,
        input  cmd_ready, pld_ready, data_out, busy, frame_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_channel, cmd_len, cmd_bad_crc, pld_valid, pld_data,
        output cmd_ready, pld_ready, data_out, busy, frame_done, cmd_err
    );
endinterface

// File: rtl/frame_tx_packer.sv
// -----------------------------------------------------------------------------
// frame_tx_packer
// Accepts a transmit command and 1..MAX_WORDS payload words, buffers the whole
// payload while folding it into a CRC-16 (poly 0x1021, init 0, MSB first, no
// reflection, no final XOR), then emits one gap-free frame, one word per clock:
//   HEADER[31:16], HEADER[15:0], {8'h00, channel}, payload..., crc,
//   TRAILER[31:16], TRAILER[15:0]
// Ports:
//   clk_in : sole clock, rising edge
//   rst    : asynchronous active-high reset
//   bus    : frame_tx_packer_if.slave (command, payload and frame output)
// The frame outputs (data_out, busy, frame_done, cmd_err) are registered and
// are computed from the *next* state, so data_out always shows the word that
// belongs to the current state. This keeps cmd_ready (IDLE decode) rising in
// the very cycle in which busy falls.
// -----------------------------------------------------------------------------
module frame_tx_packer #(
    parameter logic [31:0] HEADER    = 32'hE0E0E0E0,
    parameter logic [31:0] TRAILER   = 32'h0E0E0E0E,
    parameter int unsigned MAX_WORDS = 8
) (
    input  logic              clk_in,
    input  logic              rst,
    frame_tx_packer_if.slave  bus
);

    localparam int unsigned IDX_W    = $clog2(MAX_WORDS);
    localparam logic [3:0]  MAX_LEN  = 4'(MAX_WORDS);
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        LOAD  = 4'd1,
        HDR_H = 4'd2,
        HDR_L = 4'd3,
        CHAN  = 4'd4,
        DATA  = 4'd5,
        CRC   = 4'd6,
        TRL_H = 4'd7,
        TRL_L = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_chan;
    logic [3:0]  r_len;
    logic        r_bad_crc;
    logic [3:0]  r_idx;          // next buffer slot to fill
    logic [3:0]  r_didx;         // buffer slot currently on data_out
    logic [15:0] r_crc;
    logic [15:0] r_buf [MAX_WORDS];

    logic [15:0] r_data_out;
    logic        r_busy;
    logic        r_frame_done;
    logic        r_cmd_err;

    logic        w_cmd_ready;
    logic        w_pld_ready;
    logic        w_cmd_fire;
    logic        w_pld_fire;
    logic        w_cmd_ok;
    logic        w_last_load;
    logic        w_last_data;
    logic [3:0]  w_didx_next;
    logic [15:0] w_word_next;

    // True when exactly one bit of the channel select is set.
    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    // One CRC-16 step over a full 16-bit word, MSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    // Ready signals decode the state only; cmd_ready is held low during reset.
    assign w_cmd_ready = (r_state == IDLE) && !rst;
    assign w_pld_ready = (r_state == LOAD);

    assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
    assign w_pld_fire  = bus.pld_valid && w_pld_ready;
    assign w_cmd_ok    = is_onehot8(bus.cmd_channel) &&
                         (bus.cmd_len != 4'd0) &&
                         (bus.cmd_len <= MAX_LEN);
    assign w_last_load = (r_idx  == (r_len - 4'd1));
    assign w_last_data = (r_didx == (r_len - 4'd1));

    // Next-state logic for the load/emit sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire && w_cmd_ok) begin
                    w_next = LOAD;
                end else begin
                    w_next = IDLE;
                end
            end
            LOAD: begin
                if (w_pld_fire && w_last_load) begin
                    w_next = HDR_H;
                end else begin
                    w_next = LOAD;
                end
            end
            HDR_H: w_next = HDR_L;
            HDR_L: w_next = CHAN;
            CHAN:  w_next = DATA;
            DATA: begin
                if (w_last_data) begin
                    w_next = CRC;
                end else begin
                    w_next = DATA;
                end
            end
            CRC:   w_next = TRL_H;
            TRL_H: w_next = TRL_L;
            TRL_L: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Word to register onto data_out, selected by the state being entered.
    always_comb begin
        w_word_next = 16'h0000;
        if (r_state == DATA) begin
            w_didx_next = r_didx + 4'd1;
        end else begin
            w_didx_next = 4'd0;
        end
        case (w_next)
            HDR_H: w_word_next = HEADER[31:16];
            HDR_L: w_word_next = HEADER[15:0];
            CHAN:  w_word_next = {8'h00, r_chan};
            DATA:  w_word_next = r_buf[w_didx_next[IDX_W-1:0]];
            CRC:   w_word_next = r_bad_crc ? ~r_crc : r_crc;
            TRL_H: w_word_next = TRAILER[31:16];
            TRL_L: w_word_next = TRAILER[15:0];
            default: w_word_next = 16'h0000;
        endcase
    end

    // State register plus command latch, load index and running CRC.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_chan    <= 8'h00;
            r_len     <= 4'd0;
            r_bad_crc <= 1'b0;
            r_idx     <= 4'd0;
            r_didx    <= 4'd0;
            r_crc     <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_cmd_fire && w_cmd_ok) begin
                r_chan    <= bus.cmd_channel;
                r_len     <= bus.cmd_len;
                r_bad_crc <= bus.cmd_bad_crc;
                r_idx     <= 4'd0;
                r_crc     <= 16'h0000;
            end else if (w_pld_fire) begin
                r_idx <= r_idx + 4'd1;
                r_crc <= crc16_word(r_crc, bus.pld_data);
            end
            if (w_next == DATA) begin
                r_didx <= w_didx_next;
            end
        end
    end

    // Payload buffer; contents are irrelevant until written, so no reset.
    always_ff @(posedge clk_in) begin
        if (w_pld_fire) begin
            r_buf[r_idx[IDX_W-1:0]] <= bus.pld_data;
        end
    end

    // Registered frame outputs; reset clears them asynchronously, truncating
    // any frame in flight without a frame_done.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_data_out   <= 16'h0000;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_data_out   <= w_word_next;
            r_busy       <= (w_next != IDLE);
            r_frame_done <= (w_next == TRL_L);
            r_cmd_err    <= w_cmd_fire && !w_cmd_ok;
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.pld_ready  = w_pld_ready;
    assign bus.data_out   = r_data_out;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.cmd_err    = r_cmd_err;

endmodule
